// File: rtl/e1ofn_rtl_bridge_if.sv
// Channel bundle for e1ofn_rtl_bridge: the QDI e1ofN rails on both sides plus the RTL valid/ready ports.
// master = bridge side, slave = environment (channel peers and RTL logic).
interface e1ofn_rtl_bridge_if #(
   parameter int M = 9,
   parameter int N = 2
);
   localparam int L = $clog2(N);
   localparam int W = M * L;

   logic [M*N-1:0] in_rails;
   logic           in_e;
   logic [W-1:0]   rx_data;
   logic           rx_valid;
   logic           rx_ready;
   logic [W-1:0]   tx_data;
   logic           tx_valid;
   logic           tx_ready;
   logic [M*N-1:0] out_rails;
   logic           out_e;
   logic           err;

   modport master (
      input  in_rails,
      output in_e,
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output out_rails,
      input  out_e,
      output err
   );

   modport slave (
      output in_rails,
      input  in_e,
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  out_rails,
      output out_e,
      input  err
   );
endinterface

// File: rtl/e1ofn_rtl_bridge.sv
// Bidirectional e1ofN <-> valid/ready bridge; RX decodes 1-of-N tokens, TX encodes words into tokens.
// Define E1OFN_BRIDGE_SYNC_EN to use 2-flop synchronizers on in_rails and out_e instead of one sample flop.
module e1ofn_rtl_bridge #(
   parameter int M = 9,
   parameter int N = 2
) (
   input  logic               CLK,
   input  logic               _RESET,
   e1ofn_rtl_bridge_if.master bus
);
   localparam int L  = $clog2(N);
   localparam int W  = M * L;
   localparam int MN = M * N;
   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {RX_IDLE, RX_FULL, RX_NEUTRAL} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_RESET} tx_state_t;

   logic [MN-1:0] r_in_rails_s;
   logic          r_out_e_s;

`ifdef E1OFN_BRIDGE_SYNC_EN
   logic [MN-1:0] r_in_rails_m;
   logic          r_out_e_m;

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         r_in_rails_m <= '0;
         r_in_rails_s <= '0;
         r_out_e_m    <= 1'b0;
         r_out_e_s    <= 1'b0;
      end else begin
         r_in_rails_m <= bus.in_rails;
         r_in_rails_s <= r_in_rails_m;
         r_out_e_m    <= bus.out_e;
         r_out_e_s    <= r_out_e_m;
      end
   end
`else
   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         r_in_rails_s <= '0;
         r_out_e_s    <= 1'b0;
      end else begin
         r_in_rails_s <= bus.in_rails;
         r_out_e_s    <= bus.out_e;
      end
   end
`endif

   // Per-digit decode of sampled RX rails and one-hot encode of tx_data.
   logic [M-1:0]  w_dig_one;
   logic [M-1:0]  w_dig_multi;
   logic [W-1:0]  w_rx_word;
   logic [MN-1:0] w_tx_code;

   genvar gi;
   generate
      for (gi = 0; gi < M; gi++) begin : g_digit
         logic [N-1:0] w_rails;
         logic [L-1:0] w_dig_val;

         assign w_rails          = r_in_rails_s[gi*N +: N];
         assign w_dig_one[gi]    = (w_rails != '0) && ((w_rails & (w_rails - ONE_N)) == '0);
         assign w_dig_multi[gi]  = (w_rails & (w_rails - ONE_N)) != '0;
         assign w_rx_word[gi*L +: L] = w_dig_val;
         assign w_tx_code[gi*N +: N] = ONE_N << bus.tx_data[gi*L +: L];

         always_comb begin
            w_dig_val = '0;
            for (int k = 0; k < N; k++) begin
               if (w_rails[k]) begin
                  w_dig_val = w_dig_val | L'(k);
               end
            end
         end
      end
   endgenerate

   logic w_complete;
   logic w_neutral;
   logic w_multi;

   assign w_complete = &w_dig_one;
   assign w_neutral  = (r_in_rails_s == '0);
   assign w_multi    = |w_dig_multi;

   // ---------------- RX FSM ----------------
   rx_state_t    r_rx_state;
   rx_state_t    w_rx_state_next;
   logic         r_in_e;
   logic         w_in_e_next;
   logic         r_rx_valid;
   logic         w_rx_valid_next;
   logic [W-1:0] r_rx_data;
   logic [W-1:0] w_rx_data_next;
   logic         r_err;
   logic         w_err_next;
   logic         w_rx_hs;

   assign w_rx_hs = r_rx_valid && bus.rx_ready;

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         r_rx_state <= RX_IDLE;
         r_in_e     <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_next;
         r_in_e     <= w_in_e_next;
         r_rx_valid <= w_rx_valid_next;
         r_rx_data  <= w_rx_data_next;
         r_err      <= w_err_next;
      end
   end

   always_comb begin
      w_rx_state_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:    if (w_complete) w_rx_state_next = RX_FULL;
         RX_FULL:    if (w_rx_hs)    w_rx_state_next = w_neutral ? RX_IDLE : RX_NEUTRAL;
         RX_NEUTRAL: if (w_neutral)  w_rx_state_next = RX_IDLE;
         default:                    w_rx_state_next = RX_IDLE;
      endcase
   end

   // Multi-hot digits only count as errors while waiting for a token.
   always_comb begin
      w_in_e_next     = r_in_e;
      w_rx_valid_next = r_rx_valid;
      w_rx_data_next  = r_rx_data;
      w_err_next      = r_err | ((r_rx_state == RX_IDLE) && w_multi);
      case (r_rx_state)
         RX_IDLE: begin
            w_in_e_next = 1'b1;
            if (w_complete) begin
               w_rx_data_next  = w_rx_word;
               w_rx_valid_next = 1'b1;
               w_in_e_next     = 1'b0;
            end
         end
         RX_FULL: begin
            if (w_rx_hs) begin
               w_rx_valid_next = 1'b0;
               w_in_e_next     = w_neutral;
            end
         end
         RX_NEUTRAL: begin
            if (w_neutral) w_in_e_next = 1'b1;
         end
         default: begin
            w_in_e_next     = 1'b1;
            w_rx_valid_next = 1'b0;
         end
      endcase
   end

   assign bus.in_e     = r_in_e;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_data  = r_rx_data;
   assign bus.err      = r_err;

   // ---------------- TX FSM ----------------
   tx_state_t     r_tx_state;
   tx_state_t     w_tx_state_next;
   logic [MN-1:0] r_out_rails;
   logic [MN-1:0] w_out_rails_next;
   logic          w_tx_ready;
   logic          w_tx_accept;

   assign w_tx_ready  = (r_tx_state == TX_IDLE) && r_out_e_s;
   assign w_tx_accept = bus.tx_valid && w_tx_ready;

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         r_tx_state  <= TX_IDLE;
         r_out_rails <= '0;
      end else begin
         r_tx_state  <= w_tx_state_next;
         r_out_rails <= w_out_rails_next;
      end
   end

   always_comb begin
      w_tx_state_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:  if (w_tx_accept) w_tx_state_next = TX_DATA;
         TX_DATA:  if (!r_out_e_s)  w_tx_state_next = TX_RESET;
         TX_RESET: if (r_out_e_s)   w_tx_state_next = TX_IDLE;
         default:                   w_tx_state_next = TX_IDLE;
      endcase
   end

   // Rails only move code->neutral or neutral->code, never code->code.
   always_comb begin
      w_out_rails_next = r_out_rails;
      case (r_tx_state)
         TX_IDLE:  if (w_tx_accept) w_out_rails_next = w_tx_code;
         TX_DATA:  if (!r_out_e_s)  w_out_rails_next = '0;
         TX_RESET:                  w_out_rails_next = '0;
         default:                   w_out_rails_next = '0;
      endcase
   end

   assign bus.tx_ready  = w_tx_ready;
   assign bus.out_rails = r_out_rails;
endmodule

// File: tb/tb_e1ofn_rtl_bridge.sv
// Directed bench for e1ofn_rtl_bridge (M=9, N=2, single sample flop); scoreboard queues hold expected RX words and TX codes.
module tb_e1ofn_rtl_bridge;
   localparam int M  = 9;
   localparam int N  = 2;
   localparam int W  = 9;
   localparam int MN = 18;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   e1ofn_rtl_bridge_if #(.M(M), .N(N)) bus ();

   e1ofn_rtl_bridge #(.M(M), .N(N)) dut (
      .CLK    (clk),
      ._RESET (rst_n),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0]  rx_q[$];
   logic [MN-1:0] tx_q[$];
   logic [MN-1:0] tx_last;

   function automatic logic [MN-1:0] enc(input logic [W-1:0] w);
      logic [MN-1:0] r;
      r = '0;
      for (int i = 0; i < M; i++) r[2*i + int'(w[i])] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_send(input logic [W-1:0] w);
      int n;
      logic [W-1:0] e;
      n = 0;
      bus.in_rails = enc(w);
      rx_q.push_back(w);
      while (bus.rx_valid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      e = rx_q.pop_front();
      chk("rx_latency", 64'(n), 64'd2);
      chk("rx_data", 64'(bus.rx_data), 64'(e));
      chk("rx_in_e_ack", 64'(bus.in_e), 64'd0);
      $display("[TB] rx token 0x%03h -> rx_data 0x%03h after %0d edges", w, bus.rx_data, n);
   endtask

   task automatic rx_release();
      bus.in_rails = '0;
      tick();
      chk("rx_valid_clr", 64'(bus.rx_valid), 64'd0);
      chk("rx_in_e_hold", 64'(bus.in_e), 64'd0);
      tick();
      chk("rx_in_e_ret", 64'(bus.in_e), 64'd1);
   endtask

   task automatic tx_send(input logic [W-1:0] w);
      logic [MN-1:0] e;
      chk("tx_ready_idle", 64'(bus.tx_ready), 64'd1);
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      tx_q.push_back(enc(w));
      tick();
      bus.tx_valid = 1'b0;
      bus.tx_data  = ~w;
      e = tx_q.pop_front();
      tx_last = e;
      chk("tx_rails", 64'(bus.out_rails), 64'(e));
      chk("tx_ready_busy", 64'(bus.tx_ready), 64'd0);
      $display("[TB] tx word 0x%03h -> out_rails 0x%05h", w, bus.out_rails);
   endtask

   task automatic tx_complete();
      bus.out_e = 1'b0;
      tick();
      chk("tx_rails_hold", 64'(bus.out_rails), 64'(tx_last));
      tick();
      chk("tx_rails_neutral", 64'(bus.out_rails), 64'd0);
      bus.out_e = 1'b1;
      tick();
      chk("tx_ready_reset", 64'(bus.tx_ready), 64'd0);
      tick();
      chk("tx_ready_back", 64'(bus.tx_ready), 64'd1);
   endtask

   initial begin
      logic [W-1:0]  words [6];
      logic [W-1:0]  twords[4];
      logic [MN-1:0] tmp;

      words  = '{9'h1A5, 9'h000, 9'h1FF, 9'h0AA, 9'h155, 9'h001};
      twords = '{9'h0F3, 9'h000, 9'h1FF, 9'h12C};

      rst_n        = 1'b0;
      bus.in_rails = '0;
      bus.rx_ready = 1'b0;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      bus.out_e    = 1'b0;
      repeat (3) tick();
      chk("rst_in_e", 64'(bus.in_e), 64'd1);
      chk("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
      chk("rst_rx_data", 64'(bus.rx_data), 64'd0);
      chk("rst_out_rails", 64'(bus.out_rails), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_tx_ready", 64'(bus.tx_ready), 64'd0);
      rst_n = 1'b1;
      tick();

      // RX tokens with the consumer always ready
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rx_send(words[i]);
         rx_release();
      end
      for (int i = 0; i < 3; i++) begin
         rx_send(W'($urandom_range(0, 511)));
         rx_release();
      end

      // Backpressure; sender drops to neutral while the word is still held
      bus.rx_ready = 1'b0;
      rx_send(9'h15A);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_data", 64'(bus.rx_data), 64'h15A);
         chk("bp_valid", 64'(bus.rx_valid), 64'd1);
         chk("bp_in_e", 64'(bus.in_e), 64'd0);
         if (i == 3) bus.in_rails = '0;
      end
      bus.rx_ready = 1'b1;
      tick();
      chk("bp_hs_valid", 64'(bus.rx_valid), 64'd0);
      chk("bp_hs_in_e", 64'(bus.in_e), 64'd1);
      $display("[TB] backpressure token 0x15A released after 10 stalled cycles");

      // Partial code must be ignored until all digits are present
      tmp = enc(9'h0C3);
      bus.in_rails = tmp & 18'h00003;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("partial_valid", 64'(bus.rx_valid), 64'd0);
         chk("partial_in_e", 64'(bus.in_e), 64'd1);
      end
      rx_send(9'h0C3);
      rx_release();

      // Digit 3 with both rails high: sticky error, no token
      bus.in_rails = enc(9'h000) | (18'h00003 << 6);
      tick();
      chk("err_pre", 64'(bus.err), 64'd0);
      tick();
      chk("err_set", 64'(bus.err), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("err_no_valid", 64'(bus.rx_valid), 64'd0);
         chk("err_in_e", 64'(bus.in_e), 64'd1);
      end
      bus.in_rails = '0;
      repeat (2) tick();
      chk("err_sticky", 64'(bus.err), 64'd1);
      rx_send(9'h033);
      rx_release();
      chk("err_sticky2", 64'(bus.err), 64'd1);
      $display("[TB] multi-hot digit 3 -> err=%0b", bus.err);

      // TX words
      bus.out_e = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         tx_send(twords[i]);
         tx_complete();
      end

      // tx_valid while out_e is low must not be accepted
      bus.out_e = 1'b0;
      tick();
      bus.tx_data  = 9'h055;
      bus.tx_valid = 1'b1;
      chk("tx_ready_low", 64'(bus.tx_ready), 64'd0);
      tick();
      chk("tx_no_accept", 64'(bus.out_rails), 64'd0);
      bus.out_e = 1'b1;
      tick();
      tx_send(9'h055);
      tx_complete();

      // Reset mid-transfer: RX full and TX holding data
      bus.rx_ready = 1'b0;
      rx_send(9'h101);
      tx_send(9'h1C7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rails", 64'(bus.out_rails), 64'd0);
      chk("mid_rst_rx_valid", 64'(bus.rx_valid), 64'd0);
      chk("mid_rst_rx_data", 64'(bus.rx_data), 64'd0);
      chk("mid_rst_in_e", 64'(bus.in_e), 64'd1);
      chk("mid_rst_err", 64'(bus.err), 64'd0);
      chk("mid_rst_tx_ready", 64'(bus.tx_ready), 64'd0);
      bus.in_rails = '0;
      tick();
      rst_n = 1'b1;
      chk("post_rst_tx_ready", 64'(bus.tx_ready), 64'd0);
      tick();
      chk("post_rst_tx_ready_up", 64'(bus.tx_ready), 64'd1);
      $display("[TB] reset during TX_DATA -> out_rails 0x%05h tx_ready %0b", bus.out_rails, bus.tx_ready);

      chk("rx_q_empty", 64'(rx_q.size()), 64'd0);
      chk("tx_q_empty", 64'(tx_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
